ram_sp_be_clr: RTL and testbench

Parametrised single-port synchronous RAM that generalises our 64 x 8 single-port RAM in width and depth. It adds per-byte write enables, a selectable read-during-write mode, a registered read path with a valid strobe, and a hardware clear engine that zero-fills the array on reset or on request. It sits between local datapath logic and its scratch storage wherever a clearable, byte-writable buffer is needed.

---
 rtl/ram_sp_be_clr.sv | 132 +++++++++++++
 tb/tb_ram_sp_be_clr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_be_clr.sv
// Single-port synchronous RAM with per-byte write enables, selectable read-during-write
// behaviour, a registered read port with valid strobe, and a zero-fill clear engine.
module ram_sp_be_clr #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int DEPTH      = 64,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic                busy_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rvalid_q;

    logic                in_range;
    logic                acc_en;
    logic                wr_acc;
    logic                clr_wr;
    logic [IDX_W-1:0]    addr_idx;
    logic [IDX_W-1:0]    mem_idx;
    logic [NB-1:0]       mem_be;
    logic [DATA_W-1:0]   mem_wdata;

    // Addresses beyond DEPTH never touch the array; reads there return zero.
    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign acc_en   = !rst && (state_q == ST_IDLE) && en;
    assign wr_acc   = acc_en && we && in_range;
    assign clr_wr   = !rst && (state_q == ST_CLEAR);
    assign addr_idx = addr[IDX_W-1:0];
    assign mem_idx  = clr_wr ? clr_ptr_q[IDX_W-1:0] : addr_idx;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            assign mem_be[gi]             = clr_wr | (wr_acc & be[gi]);
            assign mem_wdata[gi*8 +: 8]   = clr_wr ? 8'h00 : wdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_be[b]) begin
                mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    // Read port: the array is sampled before this edge's write lands, so the
    // write-first result is assembled byte by byte from wdata and the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= acc_en;
            if (acc_en) begin
                if (!in_range) begin
                    rdata_q <= '0;
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        if ((RDW_MODE != 0) && we && be[b]) begin
                            rdata_q[b*8 +: 8] <= wdata[b*8 +: 8];
                        end else begin
                            rdata_q[b*8 +: 8] <= mem[addr_idx][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr_q <= '0;
            busy_q    <= (CLR_ON_RST != 0);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q   <= ST_CLEAR;
                        clr_ptr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_ptr_q == LAST_PTR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_ram_sp_be_clr.sv
// Directed checks for ram_sp_be_clr across three configurations sharing one stimulus bus:
// A = 8x64 read-first, B = 32x64 write-first, C = 8x48 read-first with out-of-range addresses.
module tb_ram_sp_be_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        en_a, en_b, en_c;
    logic        we;
    logic [3:0]  be_s;
    logic [5:0]  addr;
    logic [31:0] wdata;

    logic        busy_a, busy_b, busy_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic [7:0]  rdata_a, rdata_c;
    logic [31:0] rdata_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    always #5 clk = ~clk;

    ram_sp_be_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .RDW_MODE(0), .CLR_ON_RST(1)) u_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
        .en(en_a), .we(we), .be(be_s[0:0]), .addr(addr), .wdata(wdata[7:0]),
        .rdata(rdata_a), .rvalid(rvalid_a)
    );

    ram_sp_be_clr #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .RDW_MODE(1), .CLR_ON_RST(1)) u_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
        .en(en_b), .we(we), .be(be_s), .addr(addr), .wdata(wdata),
        .rdata(rdata_b), .rvalid(rvalid_b)
    );

    ram_sp_be_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .RDW_MODE(0), .CLR_ON_RST(1)) u_c (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_c),
        .en(en_c), .we(we), .be(be_s[0:0]), .addr(addr), .wdata(wdata[7:0]),
        .rdata(rdata_c), .rvalid(rvalid_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access cycle; ens selects which instances see en.
    task automatic acc(input logic [2:0] ens, input logic w, input logic [5:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        en_a  = ens[0];
        en_b  = ens[1];
        en_c  = ens[2];
        we    = w;
        addr  = a;
        wdata = d;
        be_s  = b;
        tick();
        en_a = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        we = 1'b0; be_s = 4'h0; addr = '0; wdata = '0;

        // Reset and power-on clear
        tick();
        check_eq("rst_busy_a", 32'(busy_a), 32'd1);
        check_eq("rst_rdata_a", 32'(rdata_a), 32'h0);
        check_eq("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        rst = 1'b0;
        n = 0;
        while (busy_a && n < 200) begin
            tick();
            n++;
        end
        check_eq("rst_sweep_len_a", 32'(n), 32'd64);
        check_eq("rst_busy_b_done", 32'(busy_b), 32'd0);
        check_eq("rst_busy_c_done", 32'(busy_c), 32'd0);

        acc(3'b001, 1'b0, 6'd0, 32'h0, 4'h0);
        check_eq("rd0_rvalid", 32'(rvalid_a), 32'd1);
        check_eq("rd0_rdata", 32'(rdata_a), 32'h00);
        acc(3'b001, 1'b0, 6'd31, 32'h0, 4'h0);
        check_eq("rd31_rdata", 32'(rdata_a), 32'h00);
        acc(3'b001, 1'b0, 6'd63, 32'h0, 4'h0);
        check_eq("rd63_rdata", 32'(rdata_a), 32'h00);
        check_eq("rd63_rvalid", 32'(rvalid_a), 32'd1);
        tick();
        check_eq("idle_rvalid", 32'(rvalid_a), 32'd0);

        // Byte enables on the 32-bit write-first instance
        acc(3'b010, 1'b1, 6'd5, 32'hAABBCCDD, 4'hF);
        check_eq("be_wr_full", rdata_b, 32'hAABBCCDD);
        acc(3'b010, 1'b1, 6'd5, 32'h11223344, 4'b0101);
        check_eq("be_wr_part_wf", rdata_b, 32'hAA22CC44);
        acc(3'b010, 1'b0, 6'd5, 32'h0, 4'h0);
        check_eq("be_rd", rdata_b, 32'hAA22CC44);
        acc(3'b010, 1'b1, 6'd5, 32'hFFFFFFFF, 4'h0);
        check_eq("be_zero_rdata", rdata_b, 32'hAA22CC44);
        check_eq("be_zero_rvalid", 32'(rvalid_b), 32'd1);
        acc(3'b010, 1'b0, 6'd5, 32'h0, 4'h0);
        check_eq("be_zero_unchanged", rdata_b, 32'hAA22CC44);

        // Read-during-write, write-first (B)
        acc(3'b010, 1'b1, 6'd7, 32'h5A, 4'h1);
        check_eq("wf_first", rdata_b, 32'h0000005A);
        acc(3'b010, 1'b1, 6'd7, 32'hA5, 4'h1);
        check_eq("wf_rdw", rdata_b, 32'h000000A5);

        // Read-during-write, read-first (A)
        acc(3'b001, 1'b1, 6'd7, 32'h5A, 4'h1);
        check_eq("rf_first", 32'(rdata_a), 32'h00);
        acc(3'b001, 1'b1, 6'd7, 32'hA5, 4'h1);
        check_eq("rf_rdw", 32'(rdata_a), 32'h5A);
        check_eq("rf_rdw_rvalid", 32'(rvalid_a), 32'd1);
        acc(3'b001, 1'b0, 6'd7, 32'h0, 4'h0);
        check_eq("rf_after", 32'(rdata_a), 32'hA5);
        tick();
        check_eq("hold_rdata", 32'(rdata_a), 32'hA5);
        check_eq("hold_rvalid", 32'(rvalid_a), 32'd0);

        // Out-of-range on the 48-deep instance
        acc(3'b100, 1'b1, 6'd10, 32'h33, 4'h1);
        acc(3'b100, 1'b0, 6'd10, 32'h0, 4'h0);
        check_eq("c_rd10", 32'(rdata_c), 32'h33);
        acc(3'b100, 1'b1, 6'd50, 32'h77, 4'h1);
        acc(3'b100, 1'b0, 6'd50, 32'h0, 4'h0);
        check_eq("c_oor_rdata", 32'(rdata_c), 32'h00);
        check_eq("c_oor_rvalid", 32'(rvalid_c), 32'd1);
        acc(3'b100, 1'b0, 6'd18, 32'h0, 4'h0);
        check_eq("c_no_alias18", 32'(rdata_c), 32'h00);
        acc(3'b100, 1'b1, 6'd47, 32'h99, 4'h1);
        acc(3'b100, 1'b0, 6'd47, 32'h0, 4'h0);
        check_eq("c_rd47", 32'(rdata_c), 32'h99);

        // Clear request with a coincident read
        for (int i = 0; i < 64; i++) begin
            acc(3'b001, 1'b1, 6'(i), 32'(i + 1), 4'h1);
        end
        clr_req = 1'b1;
        acc(3'b001, 1'b0, 6'd3, 32'h0, 4'h0);
        clr_req = 1'b0;
        check_eq("clr_rd3_rdata", 32'(rdata_a), 32'h04);
        check_eq("clr_rd3_rvalid", 32'(rvalid_a), 32'd1);
        check_eq("clr_busy_rise", 32'(busy_a), 32'd1);
        acc(3'b001, 1'b0, 6'd3, 32'h0, 4'h0);
        check_eq("busy_rd_rvalid", 32'(rvalid_a), 32'd0);
        check_eq("busy_rd_hold", 32'(rdata_a), 32'h04);
        acc(3'b001, 1'b1, 6'd9, 32'hEE, 4'h1);
        n = 2;
        while (busy_a && n < 200) begin
            tick();
            n++;
        end
        check_eq("clr_sweep_len", 32'(n), 32'd64);
        for (int i = 0; i < 64; i++) begin
            acc(3'b001, 1'b0, 6'(i), 32'h0, 4'h0);
            check_eq($sformatf("clr_word%0d", i), 32'(rdata_a), 32'h00);
        end

        // Reset in the middle of a sweep restarts it
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (20) tick();
        check_eq("mid_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_busy", 32'(busy_a), 32'd1);
        n = 0;
        while (busy_a && n < 200) begin
            tick();
            n++;
        end
        check_eq("mid_rst_sweep_len", 32'(n), 32'd64);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
